tone_sequencer: RTL and testbench



---
 rtl/tone_sequencer.sv | 121 ++++++++++++
 tb/tb_tone_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// Song player: walks the note ROM by index, makes a square wave from each note
// period and holds each note for duration x TICK_CYCLES clock cycles.
module tone_sequencer #(
   parameter int TICK_CYCLES = 12_500_000,
   parameter int LAST_INDEX  = 19,
   parameter int SILENCE_MAX = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        stop,
   input  logic        loop,
   input  logic [19:0] note,
   input  logic [4:0]  duration,
   output logic [5:0]  number,
   output logic        speaker,
   output logic        busy,
   output logic        done
);

   localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
   localparam logic [5:0]    LAST      = 6'(LAST_INDEX);
   localparam logic [19:0]   SIL       = 20'(SILENCE_MAX);

   typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

   state_t        state_reg, state_next;
   logic [5:0]    number_reg, number_next;
   logic          speaker_reg, speaker_next;
   logic          done_reg, done_next;
   logic [19:0]   note_reg;
   logic [4:0]    dur_reg;
   logic [TW-1:0] tick_cnt_reg;
   logic [4:0]    dur_cnt_reg;
   logic [19:0]   tone_cnt_reg;

   logic [19:0] half;
   logic        silent, tone_hit, tick_wrap, note_end, last;

   assign half      = note_reg >> 1;
   assign silent    = (note_reg <= SIL) || (half == 20'd0);
   assign tone_hit  = (tone_cnt_reg == half - 20'd1);
   assign tick_wrap = (tick_cnt_reg == TICK_LAST);
   assign note_end  = tick_wrap && (dur_cnt_reg == dur_reg - 5'd1);
   assign last      = (number_reg == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start && !stop) state_next = LOAD;
         LOAD:    state_next = stop ? IDLE : PLAY;
         PLAY: begin
            if (stop)          state_next = IDLE;
            else if (note_end) state_next = (last && !loop) ? IDLE : LOAD;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy         = (state_reg != IDLE);
      done_next    = (state_reg == PLAY) && !stop && note_end && last && !loop;
      number_next  = number_reg;
      speaker_next = 1'b0;
      if (state_next == IDLE)
         number_next = 6'd0;
      else if (state_reg == PLAY && state_next == LOAD)
         number_next = last ? 6'd0 : number_reg + 6'd1;
      // Speaker only runs while staying in PLAY; entering LOAD or IDLE forces it low.
      if (state_reg == PLAY && state_next == PLAY && !silent)
         speaker_next = tone_hit ? ~speaker_reg : speaker_reg;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         number_reg   <= 6'd0;
         speaker_reg  <= 1'b0;
         done_reg     <= 1'b0;
         note_reg     <= 20'd0;
         dur_reg      <= 5'd0;
         tick_cnt_reg <= '0;
         dur_cnt_reg  <= 5'd0;
         tone_cnt_reg <= 20'd0;
      end else begin
         number_reg  <= number_next;
         speaker_reg <= speaker_next;
         done_reg    <= done_next;
         case (state_reg)
            LOAD: begin
               note_reg     <= note;
               dur_reg      <= (duration == 5'd0) ? 5'd1 : duration;
               tick_cnt_reg <= '0;
               dur_cnt_reg  <= 5'd0;
               tone_cnt_reg <= 20'd0;
            end
            PLAY: begin
               tick_cnt_reg <= tick_wrap ? '0 : tick_cnt_reg + 1'b1;
               if (tick_wrap) dur_cnt_reg <= dur_cnt_reg + 5'd1;
               if (silent || tone_hit) tone_cnt_reg <= 20'd0;
               else                    tone_cnt_reg <= tone_cnt_reg + 20'd1;
            end
            default: begin
               tick_cnt_reg <= '0;
               dur_cnt_reg  <= 5'd0;
               tone_cnt_reg <= 20'd0;
            end
         endcase
      end
   end

   assign number  = number_reg;
   assign speaker = speaker_reg;
   assign done    = done_reg;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with a 4-entry stub song and 4-cycle ticks.
module tb_tone_sequencer;

   logic        clk = 1'b0;
   logic        reset, start, stop, loop;
   logic [19:0] note;
   logic [4:0]  duration;
   logic [5:0]  number;
   logic        speaker, busy, done;

   int errors = 0;
   int checks = 0;
   int num_a [0:63];
   int spk_a [0:63];
   int busy_a[0:63];
   int done_a[0:63];

   tone_sequencer #(.TICK_CYCLES(4), .LAST_INDEX(3), .SILENCE_MAX(1)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
      .note(note), .duration(duration), .number(number),
      .speaker(speaker), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always_comb begin
      note = 20'd0;
      duration = 5'd0;
      case (number)
         6'd0: begin note = 20'd8;  duration = 5'd2; end
         6'd1: begin note = 20'd1;  duration = 5'd1; end
         6'd2: begin note = 20'd6;  duration = 5'd0; end
         6'd3: begin note = 20'd10; duration = 5'd1; end
         default: ;
      endcase
   end

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else
         $display("ok   %s: %0d", tag, got);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Records n cycles starting at the LOAD of index 0; optional stop/start pulses.
   task automatic capture(input int n, input int stop_at, input int start_at);
      for (int k = 0; k < n; k++) begin
         num_a[k]  = number;
         spk_a[k]  = speaker;
         busy_a[k] = busy;
         done_a[k] = done;
         if (k == stop_at)  stop = 1'b1;
         if (k == start_at) start = 1'b1;
         tick();
         stop  = 1'b0;
         start = 1'b0;
      end
   endtask

   task automatic kick();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      int pulses;
      reset = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
      tick(); tick();
      check("reset_number", number, 0);
      check("reset_speaker", speaker, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      reset = 1'b0;
      tick();

      // Basic song, no loop
      kick();
      capture(27, -1, -1);
      check("basic_load0_busy", busy_a[0], 1);
      check("basic_load0_number", num_a[0], 0);
      check("basic_idx0_end", num_a[8], 0);
      check("basic_idx1_start", num_a[9], 1);
      check("basic_idx1_end", num_a[13], 1);
      check("basic_idx2_start", num_a[14], 2);
      check("basic_idx3_start", num_a[19], 3);
      check("basic_idx3_end", num_a[23], 3);
      check("basic_done_at_24", done_a[24], 1);
      check("basic_busy_at_24", busy_a[24], 0);
      check("basic_busy_at_23", busy_a[23], 1);
      check("basic_number_at_24", num_a[24], 0);
      pulses = 0;
      for (int k = 0; k < 27; k++) pulses += done_a[k];
      check("basic_done_pulses", pulses, 1);

      // Tone and rest
      check("tone_spk_c4", spk_a[4], 0);
      check("tone_spk_c5", spk_a[5], 1);
      check("tone_spk_c8", spk_a[8], 1);
      pulses = 0;
      for (int k = 9; k < 14; k++) pulses += spk_a[k];
      check("rest_spk_high_count", pulses, 0);
      check("tone_idx2_c17", spk_a[17], 0);
      check("tone_idx2_c18", spk_a[18], 1);

      // Loop, then stop 3 cycles into PLAY of index 2 on the second pass
      loop = 1'b1;
      kick();
      capture(45, 42, -1);
      loop = 1'b0;
      check("loop_number_at_24", num_a[24], 0);
      check("loop_busy_at_24", busy_a[24], 1);
      check("loop_done_at_24", done_a[24], 0);
      check("loop_idx1_again", num_a[33], 1);
      check("loop_idx2_again", num_a[38], 2);
      check("stop_pre_spk", spk_a[42], 1);
      check("stop_busy", busy_a[43], 0);
      check("stop_number", num_a[43], 0);
      check("stop_speaker", spk_a[43], 0);
      check("stop_done", done_a[43], 0);
      check("stop_done_later", done_a[44], 0);

      // start and stop together from IDLE
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      check("startstop_busy", busy, 0);
      tick();
      check("startstop_busy_later", busy, 0);

      // Ignored restart during index 1 PLAY
      kick();
      capture(26, -1, 10);
      check("restart_idx1", num_a[11], 1);
      check("restart_idx2", num_a[14], 2);
      check("restart_idx3", num_a[19], 3);
      check("restart_done", done_a[24], 1);

      // Async reset mid-PLAY
      kick();
      for (int k = 0; k < 5; k++) tick();
      check("rst_pre_speaker", speaker, 1);
      check("rst_pre_busy", busy, 1);
      #2 reset = 1'b1;
      #1;
      check("rst_async_speaker", speaker, 0);
      check("rst_async_busy", busy, 0);
      check("rst_async_number", number, 0);
      check("rst_async_done", done, 0);
      tick(); tick();
      reset = 1'b0;
      tick(); tick(); tick();
      check("rst_after_busy", busy, 0);
      kick();
      check("rst_fresh_start_busy", busy, 1);
      check("rst_fresh_start_number", number, 0);
      stop = 1'b1;
      tick();
      stop = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

endmodule
